// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - round-robin arbiter for the shared graph-memory read port
//
// Purpose: lets up to NUM_REQ read clients share one memory read port. Each
// grant carries exactly one read. A level-high mem_read_ready is consumed as
// one word, and the RELEASE state waits for it to fall so the word is never
// counted twice.
//
// Ports:
//   clock            single clock; all state updates on posedge
//   reset            asynchronous, active-low
//   req              bit i high: client i wants one read
//   req_addr         client i address in bits [i*MADDR_WIDTH +: MADDR_WIDTH]
//   grant            one-hot owner of the current transaction
//   rsp_valid        one-cycle pulse on the owner's bit when the transaction ends
//   rsp_error        valid with rsp_valid; 1 = timed out, rsp_data is 0
//   rsp_data         read word, held until the next rsp_valid
//   busy             high while a transaction is in BUSY or RELEASE
//   mem_addr         latched owner address, 0 when idle
//   mem_read_enable  high only in BUSY
//   mem_read_ready   memory data-valid level
//   mem_data         memory read data

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module mem_read_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int MADDR_WIDTH    = `DEFAULT_MADDR_WIDTH,
   parameter int MDATA_WIDTH    = `DEFAULT_MDATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*MADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic                           rsp_error,
   output logic [MDATA_WIDTH-1:0]         rsp_data,
   output logic                           busy,
   output logic [MADDR_WIDTH-1:0]         mem_addr,
   output logic                           mem_read_enable,
   input  logic                           mem_read_ready,
   input  logic [MDATA_WIDTH-1:0]         mem_data
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic                   rsp_error_q, rsp_error_d;
   logic [MDATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                   busy_q, busy_d;
   logic [MADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                   mem_ren_q, mem_ren_d;

   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       cand;
   logic [NUM_REQ-1:0]     pick_onehot;
   logic [MADDR_WIDTH-1:0] pick_addr;

   // Round-robin search: start one past the last owner and wrap, so the most
   // recent owner is considered last.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((int'(last_q) + off) % NUM_REQ);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      pick_addr   = '0;
      pick_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            pick_addr      = req_addr[i*MADDR_WIDTH +: MADDR_WIDTH];
            pick_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      rsp_valid_d = '0;
      rsp_error_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      busy_d      = busy_q;
      mem_addr_d  = mem_addr_q;
      mem_ren_d   = mem_ren_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d    = pick_onehot;
               mem_addr_d = pick_addr;
               mem_ren_d  = 1'b1;
               busy_d     = 1'b1;
               last_d     = pick_idx;
               cnt_d      = '0;
               state_d    = ST_BUSY;
            end
         end

         // Ready is first looked at one edge after the grant, so a level
         // left high by the previous owner cannot complete this read.
         ST_BUSY: begin
            if (mem_read_ready || (cnt_q == CNT_LAST)) begin
               rsp_valid_d = grant_q;
               rsp_error_d = ~mem_read_ready;
               rsp_data_d  = mem_read_ready ? mem_data : '0;
               grant_d     = '0;
               mem_ren_d   = 1'b0;
               mem_addr_d  = '0;
               cnt_d       = '0;
               state_d     = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // The response was already issued; this state only swallows the
         // remainder of a long ready level. A stuck-high ready is bounded.
         ST_RELEASE: begin
            if (!mem_read_ready || (cnt_q == CNT_LAST)) begin
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            grant_d    = '0;
            busy_d     = 1'b0;
            mem_addr_d = '0;
            mem_ren_d  = 1'b0;
            cnt_d      = '0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         last_q      <= LAST_INIT;
         cnt_q       <= '0;
         grant_q     <= '0;
         rsp_valid_q <= '0;
         rsp_error_q <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_ren_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
         mem_addr_q  <= mem_addr_d;
         mem_ren_q   <= mem_ren_d;
      end
   end

   assign grant           = grant_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_error       = rsp_error_q;
   assign rsp_data        = rsp_data_q;
   assign busy            = busy_q;
   assign mem_addr        = mem_addr_q;
   assign mem_read_enable = mem_ren_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - self-checking bench for mem_read_arbiter

module tb_mem_read_arbiter;

   localparam int NR = 4;
   localparam int AW = 16;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req = '0;
   logic [NR*AW-1:0] req_addr = {16'h0133, 16'h0020, 16'h0111, 16'h0100};
   logic             mem_read_ready = 1'b0;
   logic [DW-1:0]    mem_data = '0;

   // Index 0: TIMEOUT_CYCLES=64, index 1: TIMEOUT_CYCLES=4. Same stimulus.
   logic [NR-1:0] grant_o     [2];
   logic [NR-1:0] rsp_valid_o [2];
   logic          rsp_error_o [2];
   logic [DW-1:0] rsp_data_o  [2];
   logic          busy_o      [2];
   logic [AW-1:0] mem_addr_o  [2];
   logic          ren_o       [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_read_arbiter #(.NUM_REQ(NR), .MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) u_dut (
      .clock(clk), .reset(rst_n), .req(req), .req_addr(req_addr),
      .grant(grant_o[0]), .rsp_valid(rsp_valid_o[0]), .rsp_error(rsp_error_o[0]),
      .rsp_data(rsp_data_o[0]), .busy(busy_o[0]), .mem_addr(mem_addr_o[0]),
      .mem_read_enable(ren_o[0]), .mem_read_ready(mem_read_ready), .mem_data(mem_data)
   );

   mem_read_arbiter #(.NUM_REQ(NR), .MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) u_dut_t (
      .clock(clk), .reset(rst_n), .req(req), .req_addr(req_addr),
      .grant(grant_o[1]), .rsp_valid(rsp_valid_o[1]), .rsp_error(rsp_error_o[1]),
      .rsp_data(rsp_data_o[1]), .busy(busy_o[1]), .mem_addr(mem_addr_o[1]),
      .mem_read_enable(ren_o[1]), .mem_read_ready(mem_read_ready), .mem_data(mem_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: who owns the port, whether the owner has been
   // answered, and how many edges have been spent in the current phase.
   int            m_owner    [2];
   bit            m_answered [2];
   int            m_wait     [2];
   int            m_last     [2];
   logic [AW-1:0] m_addr     [2];
   logic [DW-1:0] m_data     [2];
   logic [NR-1:0] m_pulse    [2];
   logic          m_err      [2];
   int            mc;

   function automatic int limit(input int k);
      return (k == 0) ? 64 : 4;
   endfunction

   function automatic logic [NR-1:0] exp_grant(input int k);
      if (m_owner[k] >= 0 && !m_answered[k]) return NR'(1) << m_owner[k];
      return '0;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_owner[k] = -1; m_answered[k] = 1'b0; m_wait[k] = 0; m_last[k] = NR - 1;
            m_addr[k] = '0; m_data[k] = '0; m_pulse[k] = '0; m_err[k] = 1'b0;
         end else begin
            m_pulse[k] = '0;
            m_err[k]   = 1'b0;
            if (m_owner[k] < 0) begin
               for (int s = 1; s <= NR; s++) begin
                  mc = (m_last[k] + s) % NR;
                  if (m_owner[k] < 0 && req[mc[1:0]]) begin
                     m_owner[k] = mc; m_last[k] = mc; m_wait[k] = 0; m_answered[k] = 1'b0;
                     m_addr[k] = req_addr[mc*AW +: AW];
                  end
               end
            end else if (!m_answered[k]) begin
               if (mem_read_ready || m_wait[k] == limit(k) - 1) begin
                  m_pulse[k]    = NR'(1) << m_owner[k];
                  m_err[k]      = !mem_read_ready;
                  m_data[k]     = mem_read_ready ? mem_data : '0;
                  m_answered[k] = 1'b1;
                  m_wait[k]     = 0;
               end else begin
                  m_wait[k]++;
               end
            end else begin
               if (!mem_read_ready || m_wait[k] == limit(k) - 1) begin
                  m_owner[k] = -1; m_answered[k] = 1'b0; m_wait[k] = 0;
               end else begin
                  m_wait[k]++;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d.grant", k), 64'(grant_o[k]), 64'(exp_grant(k)));
         chk($sformatf("d%0d.mem_read_enable", k), 64'(ren_o[k]), 64'(exp_grant(k) != '0));
         chk($sformatf("d%0d.mem_addr", k), 64'(mem_addr_o[k]), 64'((exp_grant(k) != '0) ? m_addr[k] : '0));
         chk($sformatf("d%0d.busy", k), 64'(busy_o[k]), 64'(m_owner[k] >= 0));
         chk($sformatf("d%0d.rsp_valid", k), 64'(rsp_valid_o[k]), 64'(m_pulse[k]));
         chk($sformatf("d%0d.rsp_error", k), 64'(rsp_error_o[k]), 64'(m_err[k]));
         chk($sformatf("d%0d.rsp_data", k), 64'(rsp_data_o[k]), 64'(m_data[k]));
      end
   end

   // Window counters on the TIMEOUT_CYCLES=64 instance, sampled 1 after negedge.
   int            ren_cnt, vld_cnt, busy_cnt, grant_cnt;
   logic [NR-1:0] last_vld;
   logic [DW-1:0] last_data;
   logic          last_err;

   task automatic clr_mon();
      ren_cnt = 0; vld_cnt = 0; busy_cnt = 0; grant_cnt = 0;
      last_vld = '0; last_data = '0; last_err = 1'b0;
   endtask

   initial forever begin
      @(negedge clk);
      #1;
      if (ren_o[0]) ren_cnt++;
      if (busy_o[0]) busy_cnt++;
      if (grant_o[0] != '0) grant_cnt++;
      if (rsp_valid_o[0] != '0) begin
         vld_cnt++;
         last_vld  = rsp_valid_o[0];
         last_data = rsp_data_o[0];
         last_err  = rsp_error_o[0];
      end
   end

   logic [NR-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   initial begin
      clr_mon();
      // Reset held with all clients requesting.
      req = 4'b1111;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_grant", 64'(grant_o[k]), 64'h0);
         chk("rst_busy", 64'(busy_o[k]), 64'h0);
         chk("rst_ren", 64'(ren_o[k]), 64'h0);
         chk("rst_rsp_valid", 64'(rsp_valid_o[k]), 64'h0);
         chk("rst_mem_addr", 64'(mem_addr_o[k]), 64'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_grant", 64'(grant_o[0]), 64'h1);
      chk("rel_mem_addr", 64'(mem_addr_o[0]), 64'h0100);
      req = '0; mem_read_ready = 1'b1; mem_data = 32'h55;
      @(negedge clk);
      chk("rel_rsp_valid", 64'(rsp_valid_o[0]), 64'h1);
      chk("rel_rsp_data", 64'(rsp_data_o[0]), 64'h55);
      mem_read_ready = 1'b0;
      @(negedge clk);

      // Single read by client 2, ready raised for the third BUSY edge.
      clr_mon();
      req = 4'b0100;
      @(negedge clk);
      chk("single_mem_addr", 64'(mem_addr_o[0]), 64'h0020);
      req = '0;
      @(negedge clk);
      @(negedge clk);
      mem_read_ready = 1'b1; mem_data = 32'h7;
      @(negedge clk);
      mem_read_ready = 1'b0;
      @(negedge clk);
      #2;
      chk("single_ren_cycles", 64'(ren_cnt), 64'd3);
      chk("single_vld_count", 64'(vld_cnt), 64'd1);
      chk("single_vld_bits", 64'(last_vld), 64'h4);
      chk("single_data", 64'(last_data), 64'h7);
      chk("single_err", 64'(last_err), 64'h0);

      // Mid-transaction reset; client 3 is next in line before it.
      req = 4'b1111;
      @(negedge clk);
      chk("pre_rst_grant", 64'(grant_o[0]), 64'h8);
      clr_mon();
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("async_grant", 64'(grant_o[k]), 64'h0);
         chk("async_ren", 64'(ren_o[k]), 64'h0);
         chk("async_busy", 64'(busy_o[k]), 64'h0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      chk("async_no_rsp", 64'(vld_cnt), 64'd0);

      // Round-robin with all clients requesting and 1-cycle ready.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("rr_grant%0d", i), 64'(grant_o[0]), 64'(rr_exp[i]));
         if (i == 0) chk("rr_first_addr", 64'(mem_addr_o[0]), 64'h0100);
         mem_read_ready = 1'b1; mem_data = 32'h1000 + DW'(i);
         if (i == 4) req = '0;
         @(negedge clk);
         mem_read_ready = 1'b0;
         @(negedge clk);
      end

      // Long ready pulse: high for 5 sampled edges while others request.
      clr_mon();
      req = 4'b0010;
      @(negedge clk);
      chk("long_grant", 64'(grant_o[0]), 64'h2);
      mem_read_ready = 1'b1; mem_data = 32'hABCD; req = 4'b1101;
      repeat (4) @(negedge clk);
      @(negedge clk);
      chk("long_busy_held", 64'(busy_o[0]), 64'h1);
      mem_read_ready = 1'b0; req = '0;
      @(negedge clk);
      #2;
      chk("long_busy_cycles", 64'(busy_cnt), 64'd6);
      chk("long_grant_cycles", 64'(grant_cnt), 64'd1);
      chk("long_vld_count", 64'(vld_cnt), 64'd1);
      chk("long_data", 64'(last_data), 64'hABCD);

      // Timeout on the TIMEOUT_CYCLES=4 instance; client 0 waits behind it.
      req = 4'b1000;
      @(negedge clk);
      chk("to_grant", 64'(grant_o[1]), 64'h8);
      req = 4'b0001;
      repeat (3) begin
         @(negedge clk);
         chk("to_early_rsp", 64'(rsp_valid_o[1]), 64'h0);
      end
      @(negedge clk);
      chk("to_rsp_valid", 64'(rsp_valid_o[1]), 64'h8);
      chk("to_rsp_error", 64'(rsp_error_o[1]), 64'h1);
      chk("to_rsp_data", 64'(rsp_data_o[1]), 64'h0);
      @(negedge clk);
      chk("to_idle", 64'(busy_o[1]), 64'h0);
      @(negedge clk);
      chk("to_next_grant", 64'(grant_o[1]), 64'h1);
      req = '0;
      repeat (150) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
